// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the LEGv8 fetch stage: FSM states, PC step and opcode field.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetchState_t;

  localparam int unsigned PC_STEP    = 4;
  localparam int unsigned OPC_MSB    = 31;
  localparam int unsigned OPC_LSB    = 21;
  localparam int unsigned INSN_W_DEF = 32;

endpackage

// File: rtl/fetch_id_reg.sv
// IF/ID pipeline register with a one-entry skid buffer for responses that
// arrive while decode is stalled.
module fetch_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int unsigned PC_W   = 64,
  parameter int unsigned INSN_W = INSN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              stall,
  input  logic              loadNew,
  input  logic              loadBuf,
  input  logic              capture,
  input  logic [PC_W-1:0]   newPc,
  input  logic [INSN_W-1:0] newInstr,
  output logic              idValid,
  output logic [PC_W-1:0]   idPc,
  output logic [INSN_W-1:0] idInstr
);

  logic              bufValid;
  logic [PC_W-1:0]   bufPc;
  logic [INSN_W-1:0] bufInstr;

  // IF/ID register: flush beats stall, stall holds everything, otherwise load or empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idValid <= 1'b0;
      idPc    <= '0;
      idInstr <= '0;
    end else if (flush) begin
      idValid <= 1'b0;
    end else if (!stall) begin
      if (loadNew) begin
        idValid <= 1'b1;
        idPc    <= newPc;
        idInstr <= newInstr;
      end else if (loadBuf && bufValid) begin
        idValid <= 1'b1;
        idPc    <= bufPc;
        idInstr <= bufInstr;
      end else begin
        idValid <= 1'b0;
      end
    end
  end

  // Skid buffer: filled when a response lands during stall, drained on release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bufValid <= 1'b0;
      bufPc    <= '0;
      bufInstr <= '0;
    end else if (flush) begin
      bufValid <= 1'b0;
    end else if (capture) begin
      bufValid <= 1'b1;
      bufPc    <= newPc;
      bufInstr <= newInstr;
    end else if (loadBuf && !stall) begin
      bufValid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch stage: PC, single-outstanding memory request FSM,
// redirect handling and the IF/ID output register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int unsigned     PC_W     = 64,
  parameter int unsigned     INSN_W   = INSN_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req_valid,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [INSN_W-1:0] imem_rsp_data,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              id_valid,
  output logic [PC_W-1:0]   id_pc,
  output logic [INSN_W-1:0] id_instr,
  output logic [10:0]       id_insOp
);

  fetchState_t     state, stateNext;
  logic [PC_W-1:0] pc, pcNext;
  logic            drop, dropNext;
  logic            reqEnable;
  logic            loadNew, loadBuf, capture;
  logic [PC_W-1:0] redirTarget;
  logic [PC_W-1:0] pcInc;

  assign redirTarget    = redirect_pc & ~PC_W'(3);
  assign pcInc          = pc + PC_W'(PC_STEP);
  assign imem_req_valid = reqEnable && (state == REQ);
  assign imem_req_addr  = pc;
  assign id_insOp       = id_instr[OPC_MSB:OPC_LSB];

  // State, PC and drop flag; reqEnable keeps the request low until the first edge out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= REQ;
      pc        <= RESET_PC;
      drop      <= 1'b0;
      reqEnable <= 1'b0;
    end else begin
      state     <= stateNext;
      pc        <= pcNext;
      drop      <= dropNext;
      reqEnable <= 1'b1;
    end
  end

  // Next-state, next-PC and IF/ID control decode; redirect always wins over stall.
  always_comb begin
    stateNext = state;
    pcNext    = pc;
    dropNext  = drop;
    loadNew   = 1'b0;
    loadBuf   = 1'b0;
    capture   = 1'b0;
    case (state)
      REQ: begin
        if (imem_req_valid && imem_req_ready) begin
          stateNext = WAIT;
          if (redirect_valid) begin
            dropNext = 1'b1;
            pcNext   = redirTarget;
          end
        end else if (redirect_valid) begin
          pcNext = redirTarget;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          // The response retires the outstanding request whatever happens to its data.
          stateNext = REQ;
          dropNext  = 1'b0;
          if (redirect_valid) begin
            pcNext = redirTarget;
          end else if (!drop) begin
            if (!stall) begin
              loadNew = 1'b1;
              pcNext  = pcInc;
            end else begin
              capture   = 1'b1;
              stateNext = HOLD;
            end
          end
        end else if (redirect_valid) begin
          dropNext = 1'b1;
          pcNext   = redirTarget;
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          stateNext = REQ;
          pcNext    = redirTarget;
        end else if (!stall) begin
          loadBuf   = 1'b1;
          pcNext    = pcInc;
          stateNext = REQ;
        end
      end
      default: stateNext = REQ;
    endcase
  end

  fetch_id_reg #(
    .PC_W  (PC_W),
    .INSN_W(INSN_W)
  ) u_idReg (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (redirect_valid),
    .stall   (stall),
    .loadNew (loadNew),
    .loadBuf (loadBuf),
    .capture (capture),
    .newPc   (pc),
    .newInstr(imem_rsp_data),
    .idValid (id_valid),
    .idPc    (id_pc),
    .idInstr (id_instr)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised bench for fetch_stage against a transaction-level fetch model.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        stall;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic [63:0] id_pc;
  logic [31:0] id_instr;
  logic [10:0] id_insOp;

  fetch_stage #(
    .PC_W    (64),
    .INSN_W  (32),
    .RESET_PC(64'h0)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr (imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .stall         (stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_pc         (id_pc),
    .id_instr      (id_instr),
    .id_insOp      (id_insOp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned nTests = 0;
  int unsigned nFail  = 0;

  // Reference model: fetch pointer, outstanding-request flags, pending queue, IF/ID contents.
  bit          mStarted;
  logic [63:0] mPc;
  bit          mOut;
  bit          mStale;
  logic [95:0] mBuf[$];
  bit          mIdValid;
  logic [63:0] mIdPc;
  logic [31:0] mIdInstr;

  // Bench-side instruction memory state.
  bit          memOut;
  logic [63:0] memAddr;
  int unsigned memDelay;
  int unsigned maxLat;
  bit          spurOk;

  task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] memWord(input logic [63:0] a);
    if (a == 64'h0) return 32'h8B020020;
    if (a == 64'h4) return 32'hF8400041;
    return (a[31:0] * 32'h9E3779B1) ^ a[63:32] ^ 32'h5A5A1234;
  endfunction

  task automatic modelReset();
    mStarted = 0;
    mPc      = 64'h0;
    mOut     = 0;
    mStale   = 0;
    mBuf.delete();
    mIdValid = 0;
    mIdPc    = 64'h0;
    mIdInstr = 32'h0;
    memOut   = 0;
    memDelay = 0;
  endtask

  task automatic modelStep(input bit rv, input logic [63:0] rpc, input bit st,
                           input bit rdy, input bit rspV);
    logic [63:0] tgt;
    logic [63:0] nPc;
    logic [31:0] nIns;
    logic [95:0] ent;
    bit          haveNew;
    bit          reqV;
    tgt     = rpc & ~64'h3;
    haveNew = 0;
    nPc     = 64'h0;
    nIns    = 32'h0;
    reqV    = mStarted && !mOut && (mBuf.size() == 0);
    if (mOut) begin
      if (rspV) begin
        mOut = 0;
        if (rv) mPc = tgt;
        else if (!mStale) begin
          if (!st) begin
            haveNew = 1;
            nPc     = mPc;
            nIns    = memWord(mPc);
            mPc     = mPc + 64'd4;
          end else begin
            mBuf.push_back({mPc, memWord(mPc)});
          end
        end
        mStale = 0;
      end else if (rv) begin
        mStale = 1;
        mPc    = tgt;
      end
    end else if (mBuf.size() != 0) begin
      if (rv) begin
        mBuf.delete();
        mPc = tgt;
      end else if (!st) begin
        ent     = mBuf.pop_front();
        haveNew = 1;
        nPc     = ent[95:32];
        nIns    = ent[31:0];
        mPc     = mPc + 64'd4;
      end
    end else begin
      if (reqV && rdy) begin
        mOut   = 1;
        mStale = rv;
      end
      if (rv) mPc = tgt;
    end
    if (rv) mIdValid = 0;
    else if (!st) begin
      mIdValid = haveNew;
      if (haveNew) begin
        mIdPc    = nPc;
        mIdInstr = nIns;
      end
    end
    mStarted = 1;
  endtask

  task automatic checkOut();
    checkEq("req_valid", imem_req_valid, mStarted && !mOut && (mBuf.size() == 0));
    checkEq("req_addr", imem_req_addr, mPc);
    checkEq("id_valid", id_valid, mIdValid);
    if (mIdValid) begin
      checkEq("id_pc", id_pc, mIdPc);
      checkEq("id_instr", id_instr, mIdInstr);
      checkEq("id_insOp", id_insOp, mIdInstr >> 21);
    end
  endtask

  task automatic checkReset(input string tag);
    checkEq({tag, "_req_valid"}, imem_req_valid, 0);
    checkEq({tag, "_req_addr"}, imem_req_addr, 0);
    checkEq({tag, "_id_valid"}, id_valid, 0);
    checkEq({tag, "_id_pc"}, id_pc, 0);
    checkEq({tag, "_id_instr"}, id_instr, 0);
    checkEq({tag, "_id_insOp"}, id_insOp, 0);
  endtask

  // One clock: check outputs, drive inputs and memory response, clock, advance model.
  task automatic step(input bit rv, input logic [63:0] rpc, input bit st, input bit rdy);
    bit          rspV;
    logic [31:0] rspD;
    bit          acc;
    checkOut();
    rspV = 0;
    rspD = 32'h0;
    if (memOut && memDelay == 0) begin
      rspV = 1;
      rspD = memWord(memAddr);
    end else if (!memOut && spurOk && $urandom_range(0, 9) == 0) begin
      rspV = 1;
      rspD = $urandom;
    end
    redirect_valid = rv;
    redirect_pc    = rpc;
    stall          = st;
    imem_req_ready = rdy;
    imem_rsp_valid = rspV;
    imem_rsp_data  = rspD;
    #1;
    acc = imem_req_valid && rdy;
    if (memOut) begin
      if (rspV) memOut = 0;
      else memDelay--;
    end
    if (acc) begin
      memOut   = 1;
      memAddr  = imem_req_addr;
      memDelay = $urandom_range(0, maxLat);
    end
    @(posedge clk);
    modelStep(rv, rpc, st, rdy, rspV);
    @(negedge clk);
  endtask

  task automatic idleInputs();
    redirect_valid = 0;
    redirect_pc    = 64'h0;
    stall          = 0;
    imem_req_ready = 0;
    imem_rsp_valid = 0;
    imem_rsp_data  = 32'h0;
  endtask

  initial begin
    bit          rv, st, rdy;
    logic [63:0] rpc;
    rst_n  = 0;
    maxLat = 0;
    spurOk = 0;
    idleInputs();
    modelReset();
    repeat (3) @(negedge clk);
    checkReset("rst");
    rst_n = 1;

    // Zero-wait memory: first two instructions at cycles 3 and 5.
    repeat (3) step(0, 64'h0, 0, 1);
    checkEq("t1_pc0", id_pc, 64'h0);
    checkEq("t1_op0", id_insOp, 11'h458);
    repeat (2) step(0, 64'h0, 0, 1);
    checkEq("t1_pc4", id_pc, 64'h4);
    checkEq("t1_op4", id_insOp, 11'h7C2);

    // Stall while the next response lands, then release.
    repeat (4) step(0, 64'h0, 1, 1);
    checkEq("stall_hold_valid", id_valid, 1);
    checkEq("stall_hold_pc", id_pc, 64'h4);
    step(0, 64'h0, 0, 1);
    checkEq("stall_rel_pc", id_pc, 64'h8);

    // Memory not ready: request held, redirect re-aims it.
    repeat (3) step(0, 64'h0, 0, 0);
    checkEq("nrdy_valid", imem_req_valid, 1);
    checkEq("nrdy_addr", imem_req_addr, 64'hC);
    step(1, 64'h203, 0, 0);
    checkEq("redir_addr", imem_req_addr, 64'h200);

    // PC wrap at the top of the address space.
    step(1, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0);
    repeat (2) step(0, 64'h0, 0, 1);
    checkEq("wrap_id_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    checkEq("wrap_addr", imem_req_addr, 64'h0);

    // Asynchronous reset with a request outstanding.
    step(0, 64'h0, 0, 1);
    #2;
    rst_n = 0;
    #1;
    checkReset("midrst");
    idleInputs();
    modelReset();
    @(negedge clk);
    rst_n = 1;

    // Random traffic with variable latency, stalls, redirects and stray responses.
    maxLat = 3;
    spurOk = 1;
    for (int i = 0; i < 3000; i++) begin
      rv  = ($urandom_range(0, 19) == 0);
      st  = ($urandom_range(0, 9) < 3);
      rdy = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 7) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else rpc = 64'($urandom_range(0, 1023));
      step(rv, rpc, st, rdy);
    end
    checkOut();

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
